gate_bist_checker: RTL

- Synthesizable on-chip counterpart to the two-input gate block: drives `a`/`b` through all four input combinations.
- After a settle delay, samples the seven gate outputs and compares them against internally computed expected values.
- Reports pass/fail, per-vector and per-output failure masks, and a failing-vector count.
- Sits beside the gate block as a built-in self-test engine; software or a top-level controller pulses `start` and reads results after `done`.

---
 rtl/gate_bist_checker.sv | 110 +++++++++++
 1 files changed

// File: rtl/gate_bist_checker.sv
// Built-in self-test engine for the two-input gate block: walks a/b through
// 00,01,10,11, samples the seven gate outputs after a settle delay and logs mismatches.
`timescale 1ns/1ps
module gate_bist_checker #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       a_out,
    output logic       b_out,
    input  logic [6:0] resp,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] fail_mask,
    output logic [6:0] err_bits,
    output logic [2:0] err_count
);
    localparam logic [3:0] LP_SETTLE = 4'(SETTLE_CYCLES);

    typedef enum logic [2:0] {IDLE, APPLY, SETTLE, SAMPLE, DONE} state_t;

    state_t     r_state, w_next;
    logic [1:0] r_idx;
    logic [3:0] r_cnt;
    logic       r_a, r_b, r_busy, r_done, r_pass;
    logic [3:0] r_fail;
    logic [6:0] r_err;
    logic [2:0] r_ecnt;
    logic [6:0] w_exp, w_mism;
    logic [2:0] w_ecnt_nxt;

    // Expected gate outputs come from the registered vector, so they line up with resp.
    assign w_exp      = {~(r_a ^ r_b), r_a ^ r_b, ~(r_a | r_b), ~(r_a & r_b), ~r_a, r_a | r_b, r_a & r_b};
    assign w_mism     = resp ^ w_exp;
    assign w_ecnt_nxt = r_ecnt + {2'b00, |w_mism};

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE, DONE: if (start) w_next = APPLY;
            APPLY:      w_next = (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;
            SETTLE:     if (r_cnt <= 4'd1) w_next = SAMPLE;
            SAMPLE:     w_next = (r_idx == 2'd3) ? DONE : APPLY;
            default:    w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_a     <= 1'b0;
            r_b     <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
            r_fail  <= '0;
            r_err   <= '0;
            r_ecnt  <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_idx  <= '0;
                        r_fail <= '0;
                        r_err  <= '0;
                        r_ecnt <= '0;
                        r_busy <= 1'b1;
                        r_done <= 1'b0;
                        r_pass <= 1'b0;
                    end
                end
                APPLY: begin
                    r_a   <= r_idx[1];
                    r_b   <= r_idx[0];
                    r_cnt <= LP_SETTLE;
                end
                SETTLE: r_cnt <= r_cnt - 4'd1;
                SAMPLE: begin
                    if (w_mism != '0) begin
                        r_fail[r_idx] <= 1'b1;
                        r_err         <= r_err | w_mism;
                        r_ecnt        <= w_ecnt_nxt;
                    end
                    if (r_idx == 2'd3) begin
                        r_busy <= 1'b0;
                        r_done <= 1'b1;
                        r_pass <= (w_ecnt_nxt == 3'd0);
                    end else begin
                        r_idx <= r_idx + 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign a_out     = r_a;
    assign b_out     = r_b;
    assign busy      = r_busy;
    assign done      = r_done;
    assign pass      = r_pass;
    assign fail_mask = r_fail;
    assign err_bits  = r_err;
    assign err_count = r_ecnt;
endmodule
